matmul_nxn_core: RTL and testbench

Parametrised N×N integer matrix-multiply core with on-chip row-addressed operand stores, a Go/Done handshake, per-run signed/unsigned mode, row-streamed results and a full flattened result register. It generalises the fixed 2×2 multiply top in width, dimension and signedness. It adds write-protection of the operand stores during a run and sits between a host load path and downstream result consumers.

---
 rtl/matmul_nxn_core.sv | 137 +++++++++++++
 tb/tb_matmul_nxn_core.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_nxn_core.sv
// matmul_nxn_core: N x N integer matrix multiply with row-addressed operand
// stores, Go/Done handshake, per-run signed/unsigned mode, row-streamed
// results and a flattened result register holding the whole C matrix.
module matmul_nxn_core #(
    parameter int N  = 2,
    parameter int DW = 32,
    localparam int AW = $clog2(N),
    localparam int OW = 2*DW + AW
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              MA_we,
    input  logic [AW-1:0]     MA_addr,
    input  logic [N*DW-1:0]   MA_din,
    input  logic              MB_we,
    input  logic [AW-1:0]     MB_addr,
    input  logic [N*DW-1:0]   MB_din,
    input  logic              Go,
    input  logic              Signed_Mode,
    output logic              Busy,
    output logic              Done,
    output logic              Row_Valid,
    output logic [AW-1:0]     Row_Idx,
    output logic [N*OW-1:0]   Row_Out,
    output logic [N*N*OW-1:0] Mult_Out,
    output logic              Wr_Err
);

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_EMIT, S_DONE} state_t;

    localparam logic [AW-1:0] LAST = AW'(N-1);

    state_t          state;
    state_t          state_nxt;
    logic [N*DW-1:0] mem_a [N];
    logic [N*DW-1:0] mem_b [N];
    logic [AW-1:0]   row_i;
    logic [AW-1:0]   col_k;
    logic            mode;
    logic [OW-1:0]   acc [N];
    logic [OW-1:0]   prod [N];
    logic [DW-1:0]   a_elem;

    // Widen an operand to the result width; sign-extend only in signed mode.
    // OW leaves room for N full-width products, so nothing can overflow.
    function automatic logic [OW-1:0] ext_op(input logic [DW-1:0] v, input logic sgn);
        ext_op = {{(OW-DW){sgn & v[DW-1]}}, v};
    endfunction

    // Operand stores: no reset, writes only land while no run is active.
    always_ff @(posedge Clk) begin
        if (MA_we && !Busy && (int'(MA_addr) < N))
            mem_a[MA_addr] <= MA_din;
        if (MB_we && !Busy && (int'(MB_addr) < N))
            mem_b[MB_addr] <= MB_din;
    end

    // One column step: A[i][k] times every B[k][j] in parallel.
    always_comb begin
        a_elem = mem_a[row_i][(N-1-int'(col_k))*DW +: DW];
        for (int j = 0; j < N; j++)
            prod[j] = ext_op(a_elem, mode) * ext_op(mem_b[col_k][(N-1-j)*DW +: DW], mode);
    end

    // State register.
    always_ff @(posedge Clk) begin
        if (Rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state: k sweeps a row in MAC, EMIT closes the row, DONE ends the run.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (Go) state_nxt = S_MAC;
            S_MAC:   if (col_k == LAST) state_nxt = S_EMIT;
            S_EMIT:  state_nxt = (row_i == LAST) ? S_DONE : S_MAC;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Run control, accumulators and result registers.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            Busy      <= 1'b0;
            Done      <= 1'b0;
            Row_Valid <= 1'b0;
            Wr_Err    <= 1'b0;
            Row_Idx   <= '0;
            Row_Out   <= '0;
            Mult_Out  <= '0;
            row_i     <= '0;
            col_k     <= '0;
            mode      <= 1'b0;
            for (int j = 0; j < N; j++) acc[j] <= '0;
        end else begin
            Done      <= 1'b0;
            Row_Valid <= 1'b0;
            if ((MA_we || MB_we) && Busy)
                Wr_Err <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (Go) begin
                        mode   <= Signed_Mode;
                        row_i  <= '0;
                        col_k  <= '0;
                        Busy   <= 1'b1;
                        Wr_Err <= 1'b0;
                        for (int j = 0; j < N; j++) acc[j] <= '0;
                    end
                end
                S_MAC: begin
                    for (int j = 0; j < N; j++) acc[j] <= acc[j] + prod[j];
                    col_k <= col_k + AW'(1);
                end
                S_EMIT: begin
                    for (int j = 0; j < N; j++) begin
                        Row_Out[(N-1-j)*OW +: OW] <= acc[j];
                        Mult_Out[((N-1-int'(row_i))*N + (N-1-j))*OW +: OW] <= acc[j];
                        acc[j] <= '0;
                    end
                    Row_Idx   <= row_i;
                    Row_Valid <= 1'b1;
                    col_k     <= '0;
                    if (row_i != LAST) row_i <= row_i + AW'(1);
                end
                S_DONE: begin
                    Done <= 1'b1;
                    Busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_nxn_core.sv
// Testbench for matmul_nxn_core: directed and randomized runs checked against
// a wide-integer reference model of C = A x B.
module tb_matmul_nxn_core;

    localparam int N  = 2;
    localparam int DW = 32;
    localparam int AW = $clog2(N);
    localparam int OW = 2*DW + AW;
    localparam int RUN_EDGES = N*(N+1) + 1;

    logic              Clk = 1'b0;
    logic              Rst = 1'b0;
    logic              MA_we = 1'b0;
    logic [AW-1:0]     MA_addr = '0;
    logic [N*DW-1:0]   MA_din = '0;
    logic              MB_we = 1'b0;
    logic [AW-1:0]     MB_addr = '0;
    logic [N*DW-1:0]   MB_din = '0;
    logic              Go = 1'b0;
    logic              Signed_Mode = 1'b0;
    logic              Busy;
    logic              Done;
    logic              Row_Valid;
    logic [AW-1:0]     Row_Idx;
    logic [N*OW-1:0]   Row_Out;
    logic [N*N*OW-1:0] Mult_Out;
    logic              Wr_Err;

    matmul_nxn_core #(.N(N), .DW(DW)) dut (
        .Clk(Clk), .Rst(Rst),
        .MA_we(MA_we), .MA_addr(MA_addr), .MA_din(MA_din),
        .MB_we(MB_we), .MB_addr(MB_addr), .MB_din(MB_din),
        .Go(Go), .Signed_Mode(Signed_Mode),
        .Busy(Busy), .Done(Done), .Row_Valid(Row_Valid),
        .Row_Idx(Row_Idx), .Row_Out(Row_Out), .Mult_Out(Mult_Out),
        .Wr_Err(Wr_Err)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Shadow copies of what the stores should hold.
    logic [DW-1:0] sa [N][N];
    logic [DW-1:0] sb [N][N];

    // Observations from the most recent run.
    int              cap_row_edge [N];
    logic [AW-1:0]   cap_row_idx  [N];
    logic [N*OW-1:0] cap_row_data [N];
    int              cap_rv_count;
    int              cap_done_edge;
    int              cap_done_count;
    logic            cap_busy_e0;
    logic            cap_wrerr_e0;
    logic            cap_busy_done;
    logic            cap_wrerr_done;
    logic [3:0]      snap_ctl;
    logic [AW-1:0]   snap_idx;
    logic [N*OW-1:0] snap_row;
    logic [N*N*OW-1:0] snap_mult;

    // Reference: C[i][j] = sum_k A[i][k]*B[k][j] in 128-bit integers, reduced to OW bits.
    function automatic logic [OW-1:0] model_c(input int i, input int j, input bit sm);
        logic signed [127:0] s, av, bv;
        s = '0;
        for (int k = 0; k < N; k++) begin
            av = {{(128-DW){sm & sa[i][k][DW-1]}}, sa[i][k]};
            bv = {{(128-DW){sm & sb[k][j][DW-1]}}, sb[k][j]};
            s  = s + av * bv;
        end
        return s[OW-1:0];
    endfunction

    function automatic logic [N*OW-1:0] exp_row(input int i, input bit sm);
        logic [N*OW-1:0] r;
        for (int j = 0; j < N; j++) r[(N-1-j)*OW +: OW] = model_c(i, j, sm);
        return r;
    endfunction

    function automatic logic [N*N*OW-1:0] exp_mult(input bit sm);
        logic [N*N*OW-1:0] m;
        for (int i = 0; i < N; i++) m[(N-1-i)*N*OW +: N*OW] = exp_row(i, sm);
        return m;
    endfunction

    function automatic logic [N*DW-1:0] pack_a(input int r);
        logic [N*DW-1:0] v;
        for (int c = 0; c < N; c++) v[(N-1-c)*DW +: DW] = sa[r][c];
        return v;
    endfunction

    function automatic logic [N*DW-1:0] pack_b(input int r);
        logic [N*DW-1:0] v;
        for (int c = 0; c < N; c++) v[(N-1-c)*DW +: DW] = sb[r][c];
        return v;
    endfunction

    task automatic write_stores();
        for (int r = 0; r < N; r++) begin
            @(negedge Clk);
            MA_we = 1'b1; MA_addr = AW'(r); MA_din = pack_a(r);
            MB_we = 1'b1; MB_addr = AW'(r); MB_din = pack_b(r);
        end
        @(negedge Clk);
        MA_we = 1'b0; MB_we = 1'b0;
    endtask

    task automatic load_unsigned_set();
        sa[0][0] = 1; sa[0][1] = 2; sa[1][0] = 3; sa[1][1] = 4;
        sb[0][0] = 5; sb[0][1] = 6; sb[1][0] = 7; sb[1][1] = 8;
        write_stores();
    endtask

    // Start a run and record what the DUT shows after each edge, returning in
    // the cycle Done is high (or after a bounded number of edges).
    task automatic run_capture(input bit sm, input int inj_edge, input int rst_edge,
                               input bit go_wr, input logic [N*DW-1:0] go_wr_data);
        int limit;
        limit = 3 * (RUN_EDGES + 1);
        cap_rv_count = 0; cap_done_count = 0; cap_done_edge = -1;
        for (int r = 0; r < N; r++) begin
            cap_row_edge[r] = -1; cap_row_idx[r] = '0; cap_row_data[r] = '0;
        end
        @(negedge Clk);
        Signed_Mode = sm; Go = 1'b1;
        if (go_wr) begin MA_we = 1'b1; MA_addr = '0; MA_din = go_wr_data; end
        @(posedge Clk); #1;
        Go = 1'b0; MA_we = 1'b0;
        cap_busy_e0 = Busy; cap_wrerr_e0 = Wr_Err;
        for (int e = 1; e <= limit; e++) begin
            @(posedge Clk); #1;
            MA_we = 1'b0; Go = 1'b0;
            if (Row_Valid) begin
                if (cap_rv_count < N) begin
                    cap_row_edge[cap_rv_count] = e;
                    cap_row_idx[cap_rv_count]  = Row_Idx;
                    cap_row_data[cap_rv_count] = Row_Out;
                end
                cap_rv_count++;
            end
            if (e == rst_edge) begin
                snap_ctl = {Busy, Done, Row_Valid, Wr_Err};
                snap_idx = Row_Idx; snap_row = Row_Out; snap_mult = Mult_Out;
                Rst = 1'b0;
            end
            if (Done) begin
                cap_done_count++; cap_done_edge = e;
                cap_busy_done = Busy; cap_wrerr_done = Wr_Err;
                break;
            end
            if (e == inj_edge) begin
                MA_we = 1'b1; MA_addr = '0; MA_din = {N{DW'(100)}}; Go = 1'b1;
            end
            if (e == rst_edge - 1) Rst = 1'b1;
        end
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        n_checks++; if ({Busy, Done, Row_Valid, Wr_Err} !== 4'b0)
            $display("FAIL reset_ctl: got %b want 0000", {Busy, Done, Row_Valid, Wr_Err}); else n_pass++;
        n_checks++; if (Row_Idx !== '0) $display("FAIL reset_idx: got %0d want 0", Row_Idx); else n_pass++;
        n_checks++; if (Row_Out !== '0) $display("FAIL reset_row: got %h want 0", Row_Out); else n_pass++;
        n_checks++; if (Mult_Out !== '0) $display("FAIL reset_mult: got %h want 0", Mult_Out); else n_pass++;
        @(negedge Clk);
        Rst = 1'b0;
    endtask

    task automatic test_unsigned();
        load_unsigned_set();
        run_capture(1'b0, -1, -1, 1'b0, '0);
        n_checks++; if (cap_busy_e0 !== 1'b1) $display("FAIL uns_busy_rise: got %b want 1", cap_busy_e0); else n_pass++;
        n_checks++; if (cap_row_edge[0] !== 3 || cap_row_idx[0] !== AW'(0))
            $display("FAIL uns_row0_timing: edge %0d idx %0d want edge 3 idx 0", cap_row_edge[0], cap_row_idx[0]); else n_pass++;
        n_checks++; if (cap_row_data[0] !== {65'd19, 65'd22})
            $display("FAIL uns_row0_data: got %h want {19,22}", cap_row_data[0]); else n_pass++;
        n_checks++; if (cap_row_edge[1] !== 6 || cap_row_idx[1] !== AW'(1))
            $display("FAIL uns_row1_timing: edge %0d idx %0d want edge 6 idx 1", cap_row_edge[1], cap_row_idx[1]); else n_pass++;
        n_checks++; if (cap_row_data[1] !== {65'd43, 65'd50})
            $display("FAIL uns_row1_data: got %h want {43,50}", cap_row_data[1]); else n_pass++;
        n_checks++; if (cap_rv_count !== 2) $display("FAIL uns_row_pulses: got %0d want 2", cap_rv_count); else n_pass++;
        n_checks++; if (cap_done_edge !== 7 || cap_busy_done !== 1'b0)
            $display("FAIL uns_done: edge %0d busy %b want edge 7 busy 0", cap_done_edge, cap_busy_done); else n_pass++;
        n_checks++; if (Mult_Out !== {65'd19, 65'd22, 65'd43, 65'd50})
            $display("FAIL uns_mult: got %h want {19,22,43,50}", Mult_Out); else n_pass++;
    endtask

    task automatic test_signed();
        sa[0][0] = 32'hFFFF_FFFF; sa[0][1] = 2; sa[1][0] = 3; sa[1][1] = 32'hFFFF_FFFC;
        sb[0][0] = 1; sb[0][1] = 0; sb[1][0] = 0; sb[1][1] = 1;
        write_stores();
        run_capture(1'b1, -1, -1, 1'b0, '0);
        n_checks++; if (Mult_Out !== {65'h1_FFFF_FFFF_FFFF_FFFF, 65'd2, 65'd3, 65'h1_FFFF_FFFF_FFFF_FFFC})
            $display("FAIL signed_mult: got %h", Mult_Out); else n_pass++;
        n_checks++; if (Mult_Out !== exp_mult(1'b1))
            $display("FAIL signed_model: got %h want %h", Mult_Out, exp_mult(1'b1)); else n_pass++;
        run_capture(1'b0, -1, -1, 1'b0, '0);
        n_checks++; if (Mult_Out[3*OW +: OW] !== 65'h0_FFFF_FFFF)
            $display("FAIL unsigned_c00: got %h want 0ffffffff", Mult_Out[3*OW +: OW]); else n_pass++;
        n_checks++; if (Mult_Out !== exp_mult(1'b0))
            $display("FAIL unsigned_model: got %h want %h", Mult_Out, exp_mult(1'b0)); else n_pass++;
    endtask

    task automatic test_maxval();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin sa[r][c] = '1; sb[r][c] = '1; end
        write_stores();
        run_capture(1'b0, -1, -1, 1'b0, '0);
        for (int x = 0; x < N*N; x++) begin
            n_checks++; if (Mult_Out[x*OW +: OW] !== 65'h1_FFFF_FFFC_0000_0002)
                $display("FAIL maxval_elem%0d: got %h want 1fffffffc00000002", x, Mult_Out[x*OW +: OW]); else n_pass++;
        end
    endtask

    task automatic test_busy_write();
        load_unsigned_set();
        run_capture(1'b0, 2, -1, 1'b0, '0);
        n_checks++; if (Mult_Out !== exp_mult(1'b0))
            $display("FAIL busy_wr_result: got %h want %h", Mult_Out, exp_mult(1'b0)); else n_pass++;
        n_checks++; if (cap_done_count !== 1 || cap_done_edge !== RUN_EDGES)
            $display("FAIL busy_wr_done: count %0d edge %0d want 1 at %0d", cap_done_count, cap_done_edge, RUN_EDGES); else n_pass++;
        n_checks++; if (cap_wrerr_done !== 1'b1) $display("FAIL busy_wr_err_set: got %b want 1", cap_wrerr_done); else n_pass++;
        @(negedge Clk);
        n_checks++; if (Wr_Err !== 1'b1) $display("FAIL busy_wr_err_sticky: got %b want 1", Wr_Err); else n_pass++;
        run_capture(1'b0, -1, -1, 1'b0, '0);
        n_checks++; if (cap_wrerr_e0 !== 1'b0) $display("FAIL busy_wr_err_clear: got %b want 0", cap_wrerr_e0); else n_pass++;
        n_checks++; if (Mult_Out !== exp_mult(1'b0))
            $display("FAIL busy_wr_store_kept: got %h want %h", Mult_Out, exp_mult(1'b0)); else n_pass++;
    endtask

    task automatic test_reset_midrun();
        load_unsigned_set();
        run_capture(1'b0, -1, 4, 1'b0, '0);
        n_checks++; if (snap_ctl !== 4'b0) $display("FAIL rst_mid_ctl: got %b want 0000", snap_ctl); else n_pass++;
        n_checks++; if (snap_idx !== '0 || snap_row !== '0)
            $display("FAIL rst_mid_row: idx %0d row %h want 0", snap_idx, snap_row); else n_pass++;
        n_checks++; if (snap_mult !== '0) $display("FAIL rst_mid_mult: got %h want 0", snap_mult); else n_pass++;
        n_checks++; if (cap_done_count !== 0) $display("FAIL rst_mid_no_done: got %0d want 0", cap_done_count); else n_pass++;
        run_capture(1'b0, -1, -1, 1'b0, '0);
        n_checks++; if (Mult_Out !== exp_mult(1'b0))
            $display("FAIL rst_mid_rerun: got %h want %h", Mult_Out, exp_mult(1'b0)); else n_pass++;
    endtask

    task automatic test_go_edge_write();
        load_unsigned_set();
        sa[0][0] = 9; sa[0][1] = 9;
        run_capture(1'b0, -1, -1, 1'b1, {32'd9, 32'd9});
        n_checks++; if (cap_row_data[0] !== {65'd108, 65'd126})
            $display("FAIL go_edge_row0: got %h want {108,126}", cap_row_data[0]); else n_pass++;
        n_checks++; if (Mult_Out !== exp_mult(1'b0))
            $display("FAIL go_edge_mult: got %h want %h", Mult_Out, exp_mult(1'b0)); else n_pass++;
    endtask

    task automatic test_random();
        bit sm;
        for (int t = 0; t < 6; t++) begin
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++) begin
                    sa[r][c] = (t == 5) ? 32'h8000_0000 : $urandom;
                    sb[r][c] = (t == 5) ? 32'h8000_0000 : $urandom;
                end
            sm = bit'($urandom_range(0, 1));
            if (t >= 4) sm = 1'b1;
            write_stores();
            run_capture(sm, -1, -1, 1'b0, '0);
            n_checks++; if (Mult_Out !== exp_mult(sm))
                $display("FAIL rand%0d_mult: got %h want %h", t, Mult_Out, exp_mult(sm)); else n_pass++;
            for (int r = 0; r < N; r++) begin
                n_checks++; if (cap_row_data[r] !== exp_row(r, sm) || cap_row_idx[r] !== AW'(r))
                    $display("FAIL rand%0d_row%0d: got %h idx %0d want %h", t, r, cap_row_data[r], cap_row_idx[r], exp_row(r, sm)); else n_pass++;
            end
            n_checks++; if (cap_done_edge !== RUN_EDGES)
                $display("FAIL rand%0d_done_edge: got %0d want %0d", t, cap_done_edge, RUN_EDGES); else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        int seen;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin sa[r][c] = $urandom; sb[r][c] = $urandom; end
        write_stores();
        run_capture(1'b1, -1, -1, 1'b0, '0);
        n_checks++; if (Mult_Out !== exp_mult(1'b1))
            $display("FAIL b2b_first: got %h want %h", Mult_Out, exp_mult(1'b1)); else n_pass++;
        // Still in the Done cycle: request the next run right away.
        Signed_Mode = 1'b0; Go = 1'b1;
        @(posedge Clk); #1;
        Go = 1'b0;
        n_checks++; if (Busy !== 1'b1 || Done !== 1'b0)
            $display("FAIL b2b_accept: busy %b done %b want 1 0", Busy, Done); else n_pass++;
        seen = -1;
        for (int e = 1; e <= 3 * RUN_EDGES; e++) begin
            @(posedge Clk); #1;
            if (Done) begin seen = e; break; end
        end
        n_checks++; if (seen !== RUN_EDGES)
            $display("FAIL b2b_done_edge: got %0d want %0d", seen, RUN_EDGES); else n_pass++;
        n_checks++; if (Mult_Out !== exp_mult(1'b0))
            $display("FAIL b2b_second: got %h want %h", Mult_Out, exp_mult(1'b0)); else n_pass++;
        @(posedge Clk); #1;
        n_checks++; if (Done !== 1'b0 || Busy !== 1'b0)
            $display("FAIL b2b_done_pulse: done %b busy %b want 0 0", Done, Busy); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_maxval();
        test_busy_write();
        test_reset_midrun();
        test_go_edge_write();
        test_random();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
